// File: rtl/img_bram_loader_pkg.sv
// Shared types and constants for the image BRAM loader: FSM states and the
// port-A write payload.
package img_bram_loader_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = LANES * BYTE_W;

    typedef enum logic [1:0] {
        ST_POLL = 2'd0,
        ST_WAIT = 2'd1,
        ST_LOAD = 2'd2,
        ST_FLAG = 2'd3
    } state_e;

    typedef struct packed {
        logic [LANES-1:0]  we;
        logic [WORD_W-1:0] data;
    } porta_wr_t;

    // Full-word or no-word write enable; partial byte writes are never issued.
    function automatic logic [LANES-1:0] we_mask(input logic en);
        return en ? {LANES{1'b1}} : {LANES{1'b0}};
    endfunction

endpackage

// File: rtl/img_bram_loader_pix_pack4.sv
// Four-lane byte packer: collects pixels into lanes 0..3 and presents the
// completed word combinationally in the cycle lane 3 is loaded.
module pix_pack4
    import img_bram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic [1:0]        lane_o,
    output logic              word_valid_c,
    output logic [WORD_W-1:0] word_c
);

    logic [1:0]          lane_q, lane_d;
    logic [3*BYTE_W-1:0] pack_q, pack_d;

    always_comb begin
        lane_d = lane_q;
        pack_d = pack_q;
        if (clear_i) begin
            lane_d = '0;
            pack_d = '0;
        end else if (load_i) begin
            lane_d = lane_q + 2'd1;
            case (lane_q)
                2'd0:    pack_d[0        +: BYTE_W] = data_i;
                2'd1:    pack_d[BYTE_W   +: BYTE_W] = data_i;
                2'd2:    pack_d[2*BYTE_W +: BYTE_W] = data_i;
                default: pack_d = pack_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
            pack_q <= '0;
        end else begin
            lane_q <= lane_d;
            pack_q <= pack_d;
        end
    end

    // Lane 3 goes straight into the MSB byte, so the word is ready without an extra cycle.
    assign word_valid_c = load_i && !clear_i && (lane_q == 2'd3);
    assign word_c       = {data_i, pack_q};
    assign lane_o       = lane_q;

endmodule

// File: rtl/img_bram_loader.sv
// Streams a raster-order 8-bit image into BRAM port A, four pixels per word,
// last pixel at word 0, then writes the ready flag once the consumer has cleared it.
module img_bram_loader
    import img_bram_loader_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       PIX_W     = 28,
    parameter int unsigned       PIX_H     = 28,
    parameter int unsigned       ADDR_W    = 11,
    parameter int unsigned       RD_LAT    = 1,
    parameter logic [WORD_W-1:0] FLAG_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  s_pix_data,
    input  logic              s_pix_valid,
    output logic              s_pix_ready,
    output logic [ADDR_W-1:0] addra,
    output logic [LANES-1:0]  wea,
    output logic [WORD_W-1:0] dina,
    input  logic [WORD_W-1:0] douta,
    output logic              busy,
    output logic              img_done
);

    localparam int unsigned NPIX      = PIX_W * PIX_H;
    localparam int unsigned NWORDS    = NPIX / LANES;
    localparam int unsigned FLAG_ADDR = NWORDS;
    localparam int unsigned CNT_W     = $clog2(NPIX);

    state_e            st_q, st_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [1:0]        lat_q, lat_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              img_done_q, img_done_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    porta_wr_t         wr_q, wr_d;

    logic              accept_c;
    logic              last_c;
    logic              clear_c;
    logic [1:0]        lane;
    logic              word_valid_c;
    logic [WORD_W-1:0] word_c;

    assign accept_c = ready_q && s_pix_valid;
    assign last_c   = accept_c && (lane == 2'd3) && (pix_cnt_q == CNT_W'(NPIX - 1));

    pix_pack4 u_pack (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear_c),
        .load_i       (accept_c),
        .data_i       (s_pix_data),
        .lane_o       (lane),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Next state, counters and the port-A values for the following cycle.
    always_comb begin
        st_d       = st_q;
        pix_cnt_d  = pix_cnt_q;
        lat_d      = lat_q;
        done_d     = done_q;
        clear_c    = 1'b0;
        addra_d    = ADDR_W'(FLAG_ADDR);
        wr_d.we    = we_mask(1'b0);
        wr_d.data  = wr_q.data;
        img_done_d = 1'b0;

        case (st_q)
            ST_POLL: begin
                st_d  = ST_WAIT;
                lat_d = '0;
            end
            ST_WAIT: begin
                if (lat_q == 2'(RD_LAT - 1)) begin
                    if (douta == '0) begin
                        st_d      = ST_LOAD;
                        pix_cnt_d = '0;
                        done_d    = 1'b0;
                        clear_c   = 1'b1;
                    end else begin
                        st_d = ST_POLL;
                    end
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_LOAD: begin
                if (accept_c && (pix_cnt_q != CNT_W'(NPIX - 1))) begin
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                end
                if (last_c) begin
                    done_d = 1'b1;
                end
                // One drain cycle lets the word-0 write go out before the flag.
                if (done_q) begin
                    st_d = ST_FLAG;
                end
            end
            default: begin
                st_d = ST_POLL;
            end
        endcase

        if (word_valid_c) begin
            wr_d.we   = we_mask(1'b1);
            wr_d.data = word_c;
            addra_d   = ADDR_W'(NWORDS - 1) - ADDR_W'(pix_cnt_q[CNT_W-1:2]);
        end else if (st_d == ST_FLAG) begin
            wr_d.we    = we_mask(1'b1);
            wr_d.data  = FLAG_WORD;
            addra_d    = ADDR_W'(FLAG_ADDR);
            img_done_d = 1'b1;
        end

        ready_d = (st_d == ST_LOAD) && !done_d;
        busy_d  = (st_d == ST_LOAD) || (st_d == ST_FLAG);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= ST_POLL;
            pix_cnt_q  <= '0;
            lat_q      <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            img_done_q <= 1'b0;
            addra_q    <= ADDR_W'(FLAG_ADDR);
            wr_q       <= '0;
        end else begin
            st_q       <= st_d;
            pix_cnt_q  <= pix_cnt_d;
            lat_q      <= lat_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            img_done_q <= img_done_d;
            addra_q    <= addra_d;
            wr_q       <= wr_d;
        end
    end

    assign s_pix_ready = ready_q;
    assign addra       = addra_q;
    assign wea         = wr_q.we;
    assign dina        = wr_q.data;
    assign busy        = busy_q;
    assign img_done    = img_done_q;

endmodule

// File: tb/tb_img_bram_loader.sv
// Bench for img_bram_loader: BRAM model with a port B for the consumer, random
// images and gaps, and a reference packing model built from the image array.
module tb_img_bram_loader;

    localparam int          NPIX      = 784;
    localparam int          NWORDS    = 196;
    localparam int          FLAG_ADDR = 196;
    localparam logic [31:0] FLAG_WORD = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_pix_data = '0;
    logic        s_pix_valid = 1'b0;
    logic        s_pix_ready;
    logic [10:0] addra;
    logic [3:0]  wea;
    logic [31:0] dina;
    logic [31:0] douta;
    logic        busy;
    logic        img_done;

    logic [31:0] mem [0:2047];
    logic        mem_clr = 1'b1;
    logic        pb_we = 1'b0;
    logic [10:0] pb_addr = '0;
    logic [31:0] pb_din = '0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [42:0] wlog [$];
    logic [7:0]  img [0:NPIX-1];

    img_bram_loader dut (
        .clk         (clk),
        .reset       (reset),
        .s_pix_data  (s_pix_data),
        .s_pix_valid (s_pix_valid),
        .s_pix_ready (s_pix_ready),
        .addra       (addra),
        .wea         (wea),
        .dina        (dina),
        .douta       (douta),
        .busy        (busy),
        .img_done    (img_done)
    );

    always #5 clk = ~clk;

    // Dual-port BRAM model, read latency 1.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_clr) begin
            for (int i = 0; i < 2048; i++) mem[i] <= '0;
        end else begin
            if (wea == 4'hF) mem[addra] <= dina;
            if (pb_we) mem[pb_addr] <= pb_din;
        end
        douta <= mem[addra];
    end

    always @(negedge clk) begin
        if (wea != 4'h0) wlog.push_back({addra, dina});
        if (img_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Reference packing: word i holds pixels 783-4i (MSB) down to 780-4i (LSB).
    function automatic logic [31:0] exp_word(input int i);
        return {img[783 - 4*i], img[782 - 4*i], img[781 - 4*i], img[780 - 4*i]};
    endfunction

    task automatic rand_image();
        for (int p = 0; p < NPIX; p++) img[p] = 8'($urandom);
    endtask

    task automatic pb_write(input int a, input logic [31:0] d);
        @(negedge clk);
        pb_we = 1'b1; pb_addr = 11'(a); pb_din = d;
        @(negedge clk);
        pb_we = 1'b0;
    endtask

    task automatic feed(input int from, input int to, input int idle_pct,
                        output int got, output int first_cyc);
        int   p;
        int   budget;
        logic acc;
        p = from; budget = 0; first_cyc = -1;
        while (p < to && budget < 20000) begin
            @(negedge clk);
            s_pix_valid = ($urandom_range(99) >= 32'(idle_pct));
            s_pix_data  = img[p];
            acc = s_pix_valid && s_pix_ready;
            if (acc && first_cyc < 0) first_cyc = cyc;
            @(posedge clk);
            if (acc) p++;
            budget++;
        end
        @(negedge clk);
        s_pix_valid = 1'b0;
        got = p - from;
    endtask

    task automatic wait_done(input int d0);
        for (int n = 0; n < 20 && done_cnt == d0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_clr = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (s_pix_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", s_pix_ready); end
        checks++; if (wea !== 4'h0) begin errors++; $display("FAIL reset_wea got=%h exp=0", wea); end
        checks++; if (addra !== 11'(FLAG_ADDR)) begin errors++; $display("FAIL reset_addra got=%0d exp=%0d", addra, FLAG_ADDR); end
        checks++; if (dina !== 32'h0) begin errors++; $display("FAIL reset_dina got=%h exp=0", dina); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (img_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", img_done); end
        reset = 1'b0; mem_clr = 1'b0;
    endtask

    task automatic test_ramp();
        int base, d0, got, fc, bad;
        for (int p = 0; p < NPIX; p++) img[p] = 8'(p);
        base = wlog.size(); d0 = done_cnt;
        feed(0, NPIX, 0, got, fc);
        checks++; if (got != NPIX) begin errors++; $display("FAIL ramp_accepted got=%0d exp=%0d", got, NPIX); end
        checks++; if (s_pix_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ramp_drain ready=%b busy=%b exp ready=0 busy=1", s_pix_ready, busy); end
        wait_done(d0);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ramp_done_pulses got=%0d exp=1", done_cnt - d0); end
        checks++; if (done_cyc - fc != NPIX + 1) begin errors++; $display("FAIL ramp_latency got=%0d exp=%0d", done_cyc - fc, NPIX + 1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_after got=%b exp=0", busy); end
        checks++; if (wlog.size() - base != NWORDS + 1) begin errors++; $display("FAIL ramp_write_count got=%0d exp=%0d", wlog.size() - base, NWORDS + 1); end
        if (wlog.size() - base == NWORDS + 1) begin
            checks++; if (wlog[base] !== {11'd195, 32'h03020100}) begin errors++; $display("FAIL ramp_first_write got=%h exp=%h", wlog[base], {11'd195, 32'h03020100}); end
            checks++; if (wlog[base + 195] !== {11'd0, 32'h0F0E0D0C}) begin errors++; $display("FAIL ramp_last_data got=%h exp=%h", wlog[base + 195], {11'd0, 32'h0F0E0D0C}); end
            checks++; if (wlog[base + 196] !== {11'd196, FLAG_WORD}) begin errors++; $display("FAIL ramp_flag_write got=%h exp=%h", wlog[base + 196], {11'd196, FLAG_WORD}); end
            bad = 0;
            for (int k = 0; k < NWORDS; k++)
                if (wlog[base + k] !== {11'(195 - k), exp_word(195 - k)}) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL ramp_write_order bad_writes=%0d exp=0", bad); end
        end
    endtask

    task automatic test_flag_block();
        int viol, n;
        viol = 0;
        repeat (1000) begin
            @(negedge clk);
            if (s_pix_ready !== 1'b0 || wea !== 4'h0) viol++;
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL flag_block violations=%0d exp=0", viol); end
        pb_write(FLAG_ADDR, 32'h0);
        n = 0;
        while (n <= 4 && s_pix_ready !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n > 4) begin errors++; $display("FAIL flag_release cycles=%0d exp<=4", n); end
    endtask

    task automatic test_random_gaps();
        int base, d0, got, fc, bad;
        rand_image();
        base = wlog.size(); d0 = done_cnt;
        feed(0, NPIX, 30, got, fc);
        checks++; if (got != NPIX) begin errors++; $display("FAIL gaps_accepted got=%0d exp=%0d", got, NPIX); end
        wait_done(d0);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL gaps_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (wlog.size() - base != NWORDS + 1) begin errors++; $display("FAIL gaps_write_count got=%0d exp=%0d", wlog.size() - base, NWORDS + 1); end
        bad = 0;
        for (int i = 0; i < NWORDS; i++) if (mem[i] !== exp_word(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL gaps_memory bad_words=%0d exp=0", bad); end
        checks++; if (mem[FLAG_ADDR] !== FLAG_WORD) begin errors++; $display("FAIL gaps_flag got=%h exp=%h", mem[FLAG_ADDR], FLAG_WORD); end
    endtask

    task automatic test_reset_mid_load();
        int base, rbase, d0, got, fc, bad, flag_wr;
        pb_write(FLAG_ADDR, 32'h0);
        rand_image();
        base = wlog.size();
        feed(0, 399, 0, got, fc);
        checks++; if (got != 399) begin errors++; $display("FAIL rst_partial_accepted got=%0d exp=399", got); end
        @(negedge clk);
        s_pix_valid = 1'b1; s_pix_data = img[399]; reset = 1'b1;
        @(negedge clk);
        checks++; if (wea !== 4'h0) begin errors++; $display("FAIL rst_wea got=%h exp=0", wea); end
        checks++; if (wlog.size() - base != 99) begin errors++; $display("FAIL rst_partial_writes got=%0d exp=99", wlog.size() - base); end
        s_pix_valid = 1'b0; reset = 1'b0;
        flag_wr = 0;
        for (int k = base; k < wlog.size(); k++) if (wlog[k][42:32] == 11'(FLAG_ADDR)) flag_wr++;
        checks++; if (flag_wr != 0 || mem[FLAG_ADDR] !== 32'h0) begin errors++; $display("FAIL rst_no_flag writes=%0d mem=%h exp 0", flag_wr, mem[FLAG_ADDR]); end
        rand_image();
        rbase = wlog.size(); d0 = done_cnt;
        feed(0, NPIX, 0, got, fc);
        wait_done(d0);
        checks++; if (wlog.size() <= rbase || wlog[rbase] !== {11'd195, exp_word(195)}) begin errors++; $display("FAIL rst_reload_first got=%h exp=%h", (wlog.size() > rbase) ? wlog[rbase] : 43'h0, {11'd195, exp_word(195)}); end
        bad = 0;
        for (int i = 0; i < NWORDS; i++) if (mem[i] !== exp_word(i)) bad++;
        checks++; if (bad != 0 || done_cnt - d0 != 1) begin errors++; $display("FAIL rst_reload_memory bad_words=%0d done=%0d exp 0/1", bad, done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        int d0, got, fc, viol, clear_cyc, bad;
        pb_write(FLAG_ADDR, 32'h0);
        rand_image();
        d0 = done_cnt;
        feed(0, NPIX, 10, got, fc);
        wait_done(d0);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL b2b_first_done got=%0d exp=1", done_cnt - d0); end
        rand_image();
        viol = 0;
        s_pix_valid = 1'b1; s_pix_data = img[0];
        repeat (500) begin
            @(negedge clk);
            if (s_pix_ready !== 1'b0) viol++;
        end
        s_pix_valid = 1'b0;
        checks++; if (viol != 0) begin errors++; $display("FAIL b2b_held_off violations=%0d exp=0", viol); end
        pb_write(FLAG_ADDR, 32'h0);
        clear_cyc = cyc;
        d0 = done_cnt;
        feed(0, NPIX, 0, got, fc);
        wait_done(d0);
        checks++; if (fc <= clear_cyc - 2 || got != NPIX) begin errors++; $display("FAIL b2b_start start=%0d clear=%0d accepted=%0d", fc, clear_cyc, got); end
        bad = 0;
        for (int i = 0; i < NWORDS; i++) if (mem[i] !== exp_word(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_memory bad_words=%0d exp=0", bad); end
        checks++; if (done_cnt - d0 != 1 || mem[FLAG_ADDR] !== FLAG_WORD) begin errors++; $display("FAIL b2b_second_flag done=%0d mem=%h", done_cnt - d0, mem[FLAG_ADDR]); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp();
        test_flag_block();
        test_random_gaps();
        test_reset_mid_load();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
